dig_pll_core: RTL and testbench

- All-digital frequency-locked PLL core clocked by a fast system clock `clk`.
- A phase-accumulator DCO generates CLK_OUT. At each REF rising edge, the number of DCO rising edges counted during that REF period is compared with the target multiplier MULT, and the frequency control word (FCW) is corrected.
- The core sits between the board reference input and on-chip clock consumers. It provides a VCO_IN bypass path and a LOCK indicator.

---
 rtl/dig_pll_core_if.sv | 33 +++
 rtl/dig_pll_core.sv | 136 +++++++++++++
 tb/tb_dig_pll_core.sv | 235 +++++++++++++++++++++++
 3 files changed

// File: rtl/dig_pll_core_if.sv
// dig_pll_core_if - pin bundle of the all-digital PLL core.
//   EN_VCO  : 1 = DCO runs and loop active, 0 = bypass and freeze
//   REF     : reference clock, asynchronous to the system clock
//   VCO_IN  : external clock forwarded to CLK_OUT in bypass
//   VDDA/VDDD/VSSA/VSSD : supply pins, no functional effect
//   CLK_OUT : synthesized clock or bypass clock
//   LOCK    : frequency-lock indicator
//   FCW     : current frequency control word (observation)
// master = board/testbench side, slave = PLL core side.
interface dig_pll_core_if #(
   parameter int ACC_W = 16
);
   logic             EN_VCO;
   logic             REF;
   logic             VCO_IN;
   logic             VDDA;
   logic             VDDD;
   logic             VSSA;
   logic             VSSD;
   logic             CLK_OUT;
   logic             LOCK;
   logic [ACC_W-1:0] FCW;

   modport master (
      output EN_VCO, REF, VCO_IN, VDDA, VDDD, VSSA, VSSD,
      input  CLK_OUT, LOCK, FCW
   );

   modport slave (
      input  EN_VCO, REF, VCO_IN, VDDA, VDDD, VSSA, VSSD,
      output CLK_OUT, LOCK, FCW
   );
endinterface

// File: rtl/dig_pll_core.sv
// dig_pll_core - all-digital frequency-locked PLL core.
// A phase-accumulator DCO produces CLK_OUT. At every synchronized REF rising
// edge the DCO rising edges seen in the finished REF period are compared with
// MULT and the frequency control word is corrected by (error << GAIN_SH).
// Ports:
//   clk : fast system clock, all state on its rising edge
//   rst : asynchronous active-high reset
//   pll : dig_pll_core_if.slave (EN_VCO, REF, VCO_IN, supplies, CLK_OUT,
//         LOCK, FCW)
module dig_pll_core #(
   parameter int               ACC_W    = 16,
   parameter int               CNT_W    = 12,
   parameter int               MULT     = 8,
   parameter logic [ACC_W-1:0] FCW_INIT = 16'h0400,
   parameter int               GAIN_SH  = 4,
   parameter int               LOCK_TOL = 1,
   parameter int               LOCK_CNT = 4
) (
   input  logic            clk,
   input  logic            rst,
   dig_pll_core_if.slave   pll
);

   localparam int SUM_W = ACC_W + CNT_W + GAIN_SH + 2;
   localparam int LCW   = $clog2(LOCK_CNT + 1);
   localparam logic signed [SUM_W-1:0] FCW_MIN = SUM_W'(1);
   localparam logic signed [SUM_W-1:0] FCW_MAX = SUM_W'((2 ** (ACC_W - 1)) - 1);
   localparam logic signed [CNT_W:0]   MULT_E  = (CNT_W + 1)'(MULT);
   localparam logic signed [CNT_W:0]   TOL_P   = (CNT_W + 1)'(LOCK_TOL);
   localparam logic [LCW-1:0]          LOCK_N  = LCW'(LOCK_CNT);

   // ARM: next REF edge only opens a fresh window; TRACK: REF edges update FCW
   typedef enum logic {S_ARM, S_TRACK} loop_state_t;

   loop_state_t             state, state_nxt;
   logic                    en;
   logic                    ref_s1, ref_s2, ref_d, ref_rise;
   logic [ACC_W-1:0]        acc, fcw, fcw_nxt;
   logic                    dco_bit, dco_rise;
   logic [CNT_W-1:0]        cnt, cnt_eff;
   logic [LCW-1:0]          lock_cnt;
   logic                    win_end, do_upd, in_tol;
   logic signed [CNT_W:0]   err;
   logic signed [SUM_W-1:0] fcw_sum;
   logic                    unused_supply;

   assign en = pll.EN_VCO;

   // Two-flop synchronizer plus edge-detect delay flop.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         ref_s1 <= 1'b0;
         ref_s2 <= 1'b0;
         ref_d  <= 1'b0;
      end else begin
         ref_s1 <= pll.REF;
         ref_s2 <= ref_s1;
         ref_d  <= ref_s2;
      end
   end
   assign ref_rise = ref_s2 & ~ref_d;

   // Phase accumulator DCO; dco_bit is the registered accumulator MSB.
   always_ff @(posedge clk or posedge rst) begin
      if (rst) begin
         acc     <= '0;
         dco_bit <= 1'b0;
      end else if (en) begin
         acc     <= acc + fcw;
         dco_bit <= acc[ACC_W-1];
      end
   end
   // dco_bit is about to go 0->1 on this clock edge.
   assign dco_rise = en & acc[ACC_W-1] & ~dco_bit;

   // Loop FSM: state register
   always_ff @(posedge clk or posedge rst) begin
      if (rst) state <= S_ARM;
      else     state <= state_nxt;
   end

   // Loop FSM: next state
   always_comb begin
      state_nxt = state;
      if (!en)           state_nxt = S_ARM;
      else if (ref_rise) state_nxt = S_TRACK;
   end

   // Loop FSM: outputs
   always_comb begin
      win_end = en & ref_rise;
      do_upd  = en & ref_rise & (state == S_TRACK);
   end

   // A DCO edge landing on ref_rise is folded into the window that ends.
   assign cnt_eff = (dco_rise && (cnt != '1)) ? cnt + 1'b1 : cnt;

   always_ff @(posedge clk or posedge rst) begin
      if (rst)          cnt <= '0;
      else if (win_end) cnt <= '0;
      else              cnt <= cnt_eff;
   end

   // Frequency error and saturated FCW correction.
   always_comb begin
      err     = MULT_E - $signed({1'b0, cnt_eff});
      in_tol  = (err <= TOL_P) && (err >= -TOL_P);
      fcw_sum = $signed({{(SUM_W - ACC_W){1'b0}}, fcw})
              + ($signed({{(SUM_W - CNT_W - 1){err[CNT_W]}}, err}) <<< GAIN_SH);
      fcw_nxt = fcw_sum[ACC_W-1:0];
      if (fcw_sum < FCW_MIN)      fcw_nxt = FCW_MIN[ACC_W-1:0];
      else if (fcw_sum > FCW_MAX) fcw_nxt = FCW_MAX[ACC_W-1:0];
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)         fcw <= FCW_INIT;
      else if (do_upd) fcw <= fcw_nxt;
   end

   always_ff @(posedge clk or posedge rst) begin
      if (rst)              lock_cnt <= '0;
      else if (!en)         lock_cnt <= '0;
      else if (do_upd) begin
         if (!in_tol)              lock_cnt <= '0;
         else if (lock_cnt < LOCK_N) lock_cnt <= lock_cnt + 1'b1;
      end
   end

   assign pll.LOCK    = (lock_cnt >= LOCK_N);
   assign pll.CLK_OUT = en ? dco_bit : pll.VCO_IN;
   assign pll.FCW     = fcw;

   // Supply pins carry no function; they terminate in a deliberately unused net.
   assign unused_supply = ^{pll.VDDA, pll.VDDD, pll.VSSA, pll.VSSD};

endmodule

// File: tb/tb_dig_pll_core.sv
// tb_dig_pll_core - self-checking bench for dig_pll_core.
// A reference model working on an unbounded phase value predicts CLK_OUT,
// LOCK and FCW every clock; directed REF sequences plus a bypass vector table
// and a randomized segment drive the core.
module tb_dig_pll_core;

   localparam int MULT  = 8;
   localparam int FINIT = 16'h0400;

   logic clk;
   logic rst;

   dig_pll_core_if #(.ACC_W(16)) bus ();

   dig_pll_core #(
      .ACC_W(16), .CNT_W(12), .MULT(MULT), .FCW_INIT(16'h0400),
      .GAIN_SH(4), .LOCK_TOL(1), .LOCK_CNT(4)
   ) dut (
      .clk(clk),
      .rst(rst),
      .pll(bus)
   );

   initial clk = 1'b0;
   always #5 clk = ~clk;

   int n_checks = 0;
   int n_fail   = 0;

   // Reference model state
   longint m_p, m_pp;       // phase now / phase before the last advance
   int     m_fcw, m_cnt, m_run;
   bit     m_first;
   bit     r1, r2, r3;      // REF sampled at the last three clock edges

   typedef struct {
      bit          en;
      bit          vco;
      bit          exp_clk;
      bit          exp_lock;
      logic [15:0] exp_fcw;
   } vec_t;
   vec_t vecs[20];

   task automatic check(input string name, input longint act, input longint exp);
      n_checks++;
      if (act != exp) begin
         n_fail++;
         $display("FAIL %s: got %0h expected %0h at %0t", name, act, exp, $time);
      end
   endtask

   task automatic check_range(input string name, input longint act,
                              input longint lo, input longint hi);
      n_checks++;
      if (act < lo || act > hi) begin
         n_fail++;
         $display("FAIL %s: got %0h expected within %0h..%0h at %0t",
                  name, act, lo, hi, $time);
      end
   endtask

   // Effect of the next rising clk edge given the current inputs.
   task automatic model_step();
      int n_edge, total, err, f;
      bit rise;
      if (rst) begin
         m_p = 0; m_pp = 0; m_fcw = FINIT; m_cnt = 0; m_run = 0;
         m_first = 1'b1; r1 = 0; r2 = 0; r3 = 0;
         return;
      end
      rise = r2 && !r3;
      r3 = r2; r2 = r1; r1 = bus.REF;
      if (bus.EN_VCO) begin
         // rising MSB edges = crossings of 32768 + k*65536
         n_edge = int'((m_p + 32768) / 65536 - (m_pp + 32768) / 65536);
         m_pp = m_p;
         m_p  = m_p + m_fcw;
         total = m_cnt + n_edge;
         if (total > 4095) total = 4095;
         if (rise) begin
            if (m_first) m_first = 1'b0;
            else begin
               err = MULT - total;
               f = m_fcw + err * 16;
               if (f < 1) f = 1;
               if (f > 32767) f = 32767;
               m_fcw = f;
               if (err >= -1 && err <= 1) m_run++;
               else m_run = 0;
            end
            m_cnt = 0;
         end else begin
            m_cnt = total;
         end
      end else begin
         m_first = 1'b1;
         m_run = 0;
      end
   endtask

   function automatic bit exp_clk_out();
      if (bus.EN_VCO) return ((m_pp % 65536) >= 32768);
      return bus.VCO_IN;
   endfunction

   task automatic tick();
      bus.VDDA = 1'($urandom_range(0, 1));
      bus.VDDD = 1'($urandom_range(0, 1));
      bus.VSSA = 1'($urandom_range(0, 1));
      bus.VSSD = 1'($urandom_range(0, 1));
      model_step();
      @(posedge clk);
      @(negedge clk);
      check("clk_out", longint'(bus.CLK_OUT), longint'(exp_clk_out()));
      check("lock", longint'(bus.LOCK), longint'(m_run >= 4));
      check("fcw", longint'(bus.FCW), longint'(m_fcw));
   endtask

   task automatic run_ref(input int period, input int n);
      for (int p = 0; p < n; p++) begin
         bus.REF = 1'b1;
         repeat (period / 2) tick();
         bus.REF = 1'b0;
         repeat (period - period / 2) tick();
      end
   endtask

   initial begin
      int hc;
      for (int i = 0; i < 20; i++) begin
         vecs[i].en       = 1'b0;
         vecs[i].vco      = ((i / 5) % 2) == 1;
         vecs[i].exp_clk  = vecs[i].vco;
         vecs[i].exp_lock = 1'b0;
         vecs[i].exp_fcw  = 16'h0400;
      end

      rst = 1'b1;
      bus.EN_VCO = 1'b1;
      bus.REF = 1'b0;
      bus.VCO_IN = 1'b0;

      // Reset with DCO enabled and REF toggling
      for (int i = 0; i < 20; i++) begin
         bus.REF = (i % 4) < 2;
         tick();
         check("rst_lock", longint'(bus.LOCK), 0);
         check("rst_fcw", longint'(bus.FCW), 16'h0400);
         check("rst_clk_out", longint'(bus.CLK_OUT), 0);
      end
      bus.REF = 1'b0;
      rst = 1'b0;

      // Bypass vectors
      for (int i = 0; i < 20; i++) begin
         bus.EN_VCO = vecs[i].en;
         bus.VCO_IN = vecs[i].vco;
         #1;
         check("byp_clk_out", longint'(bus.CLK_OUT), longint'(vecs[i].exp_clk));
         tick();
         check("byp_lock", longint'(bus.LOCK), longint'(vecs[i].exp_lock));
         check("byp_fcw", longint'(bus.FCW), longint'(vecs[i].exp_fcw));
      end

      // Matched frequency: lock after the 5th REF edge
      bus.EN_VCO = 1'b1;
      run_ref(512, 4);
      check("match_no_lock_yet", longint'(bus.LOCK), 0);
      run_ref(512, 1);
      check("match_lock", longint'(bus.LOCK), 1);
      run_ref(512, 3);
      check_range("match_fcw", longint'(bus.FCW), 16'h03F0, 16'h0410);

      // Lock loss on REF period change, then reacquisition
      run_ref(256, 2);
      check("loss_lock", longint'(bus.LOCK), 0);
      run_ref(256, 40);
      check("reacq_lock", longint'(bus.LOCK), 1);
      check_range("reacq_fcw", longint'(bus.FCW), 16'h0700, 16'h0900);

      // Mid-operation reset
      rst = 1'b1;
      repeat (3) tick();
      check("midrst_fcw", longint'(bus.FCW), 16'h0400);
      rst = 1'b0;
      repeat (4) tick();

      // Downward acquisition: first update 8-16 = -8 -> 0x0380
      run_ref(1024, 2);
      check("down_first_fcw", longint'(bus.FCW), 16'h0380);
      run_ref(1024, 18);
      check("down_lock", longint'(bus.LOCK), 1);
      check_range("down_fcw", longint'(bus.FCW), 16'h01C0, 16'h0240);

      // Upper saturation with a very fast REF
      run_ref(10, 600);
      check("sat_hi_fcw", longint'(bus.FCW), 16'h7FFF);

      // Disable mid-window, freeze, re-enable
      repeat (3) tick();
      bus.EN_VCO = 1'b0;
      tick();
      check("dis_lock", longint'(bus.LOCK), 0);
      check("dis_fcw", longint'(bus.FCW), 16'h7FFF);
      run_ref(10, 10);
      check("dis_hold_fcw", longint'(bus.FCW), 16'h7FFF);
      bus.EN_VCO = 1'b1;
      repeat (5) tick();
      run_ref(8000, 1);
      check("reen_first_no_upd", longint'(bus.FCW), 16'h7FFF);
      run_ref(8000, 1);
      check("sat_lo_fcw", longint'(bus.FCW), 1);

      // Randomized segment against the model
      hc = 0;
      for (int i = 0; i < 3000; i++) begin
         if (hc == 0) begin
            bus.REF = ~bus.REF;
            hc = $urandom_range(3, 40);
         end else begin
            hc--;
         end
         if ($urandom_range(0, 499) == 0) bus.EN_VCO = ~bus.EN_VCO;
         bus.VCO_IN = 1'($urandom_range(0, 1));
         rst = ($urandom_range(0, 1999) == 0);
         tick();
      end
      rst = 1'b0;

      $display("End of test - %0d assertions evaluated, %0d failures", n_checks, n_fail);
      $finish;
   end

endmodule
